ddr3_wr_burst_ctrl: RTL and testbench
=====================================

Name: ddr3_wr_burst_ctrl

Overview:
- Write-side DDR3 master between the write FIFO stage (128-bit words packed from UART bytes) and the MIG user interface.
- When the write FIFO signals at least one burst of data (wr_trig) and the read/write arbiter grants access, the block drains exactly BURST_LEN 128-bit words into DDR3.
- Each word goes out as one write command plus one write-data beat at consecutive addresses; the address wraps at the frame size.
- Single clock domain: MIG ui_clk.

Parameters:
- BURST_LEN, 16, 128-bit words per burst (matches wr_trig threshold)
- ADDR_W, 28, app_addr width
- ADDR_STEP, 8, app_addr increment per word (BL8 on x16 DDR3)
- ADDR_MAX, 1024*768*2/2, exclusive upper bound of write region in app_addr units; multiple of BURST_LEN*ADDR_STEP

Ports:
- sclk  in  1  MIG ui_clk
- s_rst  in  1  asynchronous, active-high reset
- init_calib_complete  in  1  MIG calibration done
- wr_trig  in  1  write FIFO holds >= BURST_LEN words
- wr_req  out  1  request to arbiter
- wr_grant  in  1  arbiter grant, held high until wr_done
- wr_done  out  1  one-cycle pulse, burst complete
- wfifo_rd_en  out  1  FIFO pop (FWFT FIFO: wfifo_rd_data valid before pop)
- wfifo_rd_data  in  128  FIFO head word
- app_rdy  in  1  MIG command ready
- app_en  out  1  command valid
- app_cmd  out  3  always 3'b000 (write)
- app_addr  out  ADDR_W  command address
- app_wdf_rdy  in  1  MIG write-data ready
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  equals app_wdf_wren (one beat = one full burst)
- app_wdf_data  out  128  equals wfifo_rd_data
- app_wdf_mask  out  16  always 0

Behaviour:
- Reset: state IDLE; cmd_cnt, dat_cnt, base_addr, app_addr = 0; every output = 0 except app_wdf_data, which passes through.
- FSM IDLE -> REQ -> BURST -> DONE -> IDLE.
  - IDLE: wait for init_calib_complete && wr_trig, then go to REQ.
  - REQ: wr_req=1; on wr_grant=1 go to BURST, with wr_req low from the BURST cycle on. No timeout.
  - BURST: command and data channels run independently.
  - DONE: wr_done=1 for exactly one cycle; base_addr updates; next cycle returns to IDLE.
- Command channel:
  - app_en = (state==BURST && cmd_cnt<BURST_LEN).
  - A command is accepted when app_en && app_rdy; on acceptance cmd_cnt++ and app_addr += ADDR_STEP.
  - app_en, app_addr and app_cmd are held stable while app_rdy=0.
- Data channel:
  - app_wdf_wren = (state==BURST && dat_cnt<BURST_LEN).
  - A beat is accepted when app_wdf_wren && app_wdf_rdy.
  - wfifo_rd_en = app_wdf_wren && app_wdf_rdy (combinational); on acceptance dat_cnt++.
  - Data may lead or lag commands by any amount; no coupling between channels.
- BURST -> DONE when both counts == BURST_LEN (including the cycle the last acceptance registers). Peak throughput is 1 word/cycle per channel.
- Address:
  - app_addr loads base_addr on REQ -> BURST.
  - In DONE: base_addr += BURST_LEN*ADDR_STEP; if the result >= ADDR_MAX, base_addr = 0.
- wr_trig and init_calib_complete are sampled only in IDLE; changes during REQ/BURST are ignored.
- The block relies on wr_trig guaranteeing BURST_LEN words; it never checks FIFO empty.
- Dropping wr_grant mid-burst is an arbiter protocol violation; the block ignores it and completes the burst.
- s_rst mid-operation: immediate return to reset values, including base_addr=0; partial burst abandoned; no wr_done.
- Back-to-back bursts: at least one IDLE cycle between wr_done and the next wr_req.

Test Plan:
- Calib=1, wr_trig=1, grant 2 cycles after wr_req, app_rdy=app_wdf_rdy=1 -> 16 consecutive app_en cycles with addresses 0,8,...,120; 16 wfifo_rd_en pulses; wr_done one cycle later; next burst starts at 128.
- app_rdy low on cycles 3-7 of the burst, app_wdf_rdy low on cycles 10-11 -> app_addr held while stalled; exactly 16 commands and 16 beats; data order equals FIFO order; single wr_done.
- app_wdf_rdy=1, app_rdy=0 for 20 cycles, then 1 -> all 16 data beats complete first; commands follow; DONE only after the 16th command.
- ADDR_MAX=256, three bursts -> base addresses 0, 128, 0.
- init_calib_complete=0 with wr_trig=1 -> wr_req stays 0; calib rises -> wr_req asserts the next cycle.
- s_rst pulsed after 7 accepted commands -> all outputs 0 the same cycle; no wr_done; after release, next burst starts at address 0.

Source files
------------

// File: rtl/ddr3_wr_burst_ctrl_if.sv
// Handshake bundle between the DDR3 write-burst controller, the write FIFO,
// the read/write arbiter and the MIG user interface.
interface ddr3_wr_burst_ctrl_if #(
    parameter int ADDR_W = 28
);
    logic              init_calib_complete;
    logic              wr_trig;
    logic              wr_req;
    logic              wr_grant;
    logic              wr_done;
    logic              wfifo_rd_en;
    logic [127:0]      wfifo_rd_data;
    logic              app_rdy;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_wdf_rdy;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [127:0]      app_wdf_data;
    logic [15:0]       app_wdf_mask;

    modport master (
        input  init_calib_complete, wr_trig, wr_grant, wfifo_rd_data,
               app_rdy, app_wdf_rdy,
        output wr_req, wr_done, wfifo_rd_en, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );

    modport slave (
        output init_calib_complete, wr_trig, wr_grant, wfifo_rd_data,
               app_rdy, app_wdf_rdy,
        input  wr_req, wr_done, wfifo_rd_en, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );
endinterface

// File: rtl/ddr3_wr_burst_ctrl.sv
// Write-side DDR3 master: drains BURST_LEN FIFO words per arbiter grant into the
// MIG as independent command and write-data streams at consecutive addresses.
module ddr3_wr_burst_ctrl #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 28,
    parameter int ADDR_STEP = 8,
    parameter int ADDR_MAX  = 1024*768*2/2
) (
    input logic                  sclk,
    input logic                  s_rst,
    ddr3_wr_burst_ctrl_if.master bus
);

    localparam int                CNT_W      = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] ADDR_INC   = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W:0]   BURST_SPAN = (ADDR_W+1)'(BURST_LEN * ADDR_STEP);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(ADDR_MAX);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BURST,
        DONE
    } state_t;

    state_t            state_q;
    logic              wr_req_q;
    logic              wr_done_q;
    logic              app_en_q;
    logic              wdf_wren_q;
    logic [CNT_W-1:0]  cmd_cnt_q;
    logic [CNT_W-1:0]  dat_cnt_q;
    logic [ADDR_W-1:0] base_addr_q;
    logic [ADDR_W-1:0] app_addr_q;

    logic              cmd_acc;
    logic              dat_acc;
    logic [CNT_W-1:0]  cmd_cnt_d;
    logic [CNT_W-1:0]  dat_cnt_d;
    logic [ADDR_W:0]   base_sum;
    logic [ADDR_W-1:0] base_addr_d;

    // Post-acceptance counts let BURST exit on the same edge as the last handshake.
    always_comb begin
        cmd_acc     = app_en_q && bus.app_rdy;
        dat_acc     = wdf_wren_q && bus.app_wdf_rdy;
        cmd_cnt_d   = cmd_cnt_q + CNT_W'(cmd_acc);
        dat_cnt_d   = dat_cnt_q + CNT_W'(dat_acc);
        base_sum    = {1'b0, base_addr_q} + BURST_SPAN;
        base_addr_d = (base_sum >= ADDR_LIMIT) ? '0 : base_sum[ADDR_W-1:0];
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q     <= IDLE;
            wr_req_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            app_en_q    <= 1'b0;
            wdf_wren_q  <= 1'b0;
            cmd_cnt_q   <= '0;
            dat_cnt_q   <= '0;
            base_addr_q <= '0;
            app_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.init_calib_complete && bus.wr_trig) begin
                        state_q  <= REQ;
                        wr_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.wr_grant) begin
                        state_q    <= BURST;
                        wr_req_q   <= 1'b0;
                        app_addr_q <= base_addr_q;
                        cmd_cnt_q  <= '0;
                        dat_cnt_q  <= '0;
                        app_en_q   <= 1'b1;
                        wdf_wren_q <= 1'b1;
                    end
                end
                BURST: begin
                    // Command and data channels advance independently of each other.
                    cmd_cnt_q  <= cmd_cnt_d;
                    dat_cnt_q  <= dat_cnt_d;
                    app_en_q   <= (cmd_cnt_d < CNT_FULL);
                    wdf_wren_q <= (dat_cnt_d < CNT_FULL);
                    if (cmd_acc) begin
                        app_addr_q <= app_addr_q + ADDR_INC;
                    end
                    if ((cmd_cnt_d == CNT_FULL) && (dat_cnt_d == CNT_FULL)) begin
                        state_q   <= DONE;
                        wr_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    wr_done_q   <= 1'b0;
                    base_addr_q <= base_addr_d;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_req       = wr_req_q;
    assign bus.wr_done      = wr_done_q;
    assign bus.app_en       = app_en_q;
    assign bus.app_cmd      = 3'b000;
    assign bus.app_addr     = app_addr_q;
    assign bus.app_wdf_wren = wdf_wren_q;
    assign bus.app_wdf_end  = wdf_wren_q;
    assign bus.app_wdf_data = bus.wfifo_rd_data;
    assign bus.app_wdf_mask = '0;
    assign bus.wfifo_rd_en  = dat_acc;

endmodule

// File: tb/tb_ddr3_wr_burst_ctrl.sv
// Randomized scoreboard bench for ddr3_wr_burst_ctrl: a FIFO/arbiter/MIG model
// feeds bursts while a decoupled monitor checks every handshake against queues.
module tb_ddr3_wr_burst_ctrl;

    localparam int BURST_LEN = 16;
    localparam int ADDR_W    = 28;
    localparam int ADDR_STEP = 8;
    localparam int ADDR_MAX  = 384;
    localparam int TIMEOUT   = 400;

    logic sclk = 1'b0;
    logic s_rst;

    always #5 sclk = ~sclk;

    ddr3_wr_burst_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ddr3_wr_burst_ctrl #(
        .BURST_LEN(BURST_LEN),
        .ADDR_W   (ADDR_W),
        .ADDR_STEP(ADDR_STEP),
        .ADDR_MAX (ADDR_MAX)
    ) dut (
        .sclk (sclk),
        .s_rst(s_rst),
        .bus  (bus)
    );

    int testsRun    = 0;
    int failCount   = 0;
    int pendingDone = 0;
    int doneCount   = 0;
    int burstIdx    = 0;
    int mode        = 0;
    int burstCyc    = -1;
    int cmdAccInBurst = 0;
    bit popFlag     = 1'b0;

    logic [127:0]      fifoQ[$];
    logic [127:0]      expData[$];
    logic [ADDR_W-1:0] expAddr[$];

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name, input int waited);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s: event absent after %0d cycles, required within %0d",
                 name, waited, TIMEOUT);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " wr_req"},       128'(bus.wr_req), 128'(0));
        checkOutput({tag, " wr_done"},      128'(bus.wr_done), 128'(0));
        checkOutput({tag, " app_en"},       128'(bus.app_en), 128'(0));
        checkOutput({tag, " app_addr"},     128'(bus.app_addr), 128'(0));
        checkOutput({tag, " app_wdf_wren"}, 128'(bus.app_wdf_wren), 128'(0));
        checkOutput({tag, " app_wdf_end"},  128'(bus.app_wdf_end), 128'(0));
        checkOutput({tag, " wfifo_rd_en"},  128'(bus.wfifo_rd_en), 128'(0));
        checkOutput({tag, " app_cmd"},      128'(bus.app_cmd), 128'(0));
        checkOutput({tag, " app_wdf_mask"}, 128'(bus.app_wdf_mask), 128'(0));
        checkOutput({tag, " app_wdf_data"}, bus.app_wdf_data, bus.wfifo_rd_data);
    endtask

    // Reference model: burst k of a reset epoch starts at (k * span) mod ADDR_MAX,
    // and data leaves in exactly the order it entered the FIFO.
    task automatic loadBurst();
        logic [ADDR_W-1:0] base;
        logic [127:0]      word;
        base = ADDR_W'((burstIdx * BURST_LEN * ADDR_STEP) % ADDR_MAX);
        for (int i = 0; i < BURST_LEN; i++) begin
            word = {$urandom, $urandom, $urandom, $urandom};
            fifoQ.push_back(word);
            expData.push_back(word);
            expAddr.push_back(base + ADDR_W'(i * ADDR_STEP));
        end
        burstIdx++;
        pendingDone++;
    endtask

    task automatic doReset();
        s_rst = 1'b1;
        fifoQ.delete();
        expData.delete();
        expAddr.delete();
        pendingDone = 0;
        burstIdx    = 0;
        bus.wr_grant = 1'b0;
        bus.wr_trig  = 1'b0;
        repeat (2) @(posedge sclk);
        #1 s_rst = 1'b0;
    endtask

    task automatic applyStimulus(input int burstMode);
        int waited;
        int startDone;
        mode      = burstMode;
        startDone = doneCount;
        waited    = 0;
        while (!bus.wr_req && waited < TIMEOUT) begin
            @(negedge sclk);
            waited++;
        end
        if (!bus.wr_req) begin
            reportTimeout("wr_req", waited);
            doReset();
            return;
        end
        repeat ($urandom_range(0, 3)) @(negedge sclk);
        @(negedge sclk);
        cmdAccInBurst = 0;
        bus.wr_grant  = 1'b1;
        bus.wr_trig   = 1'b0;
        waited = 0;
        while (doneCount == startDone && waited < TIMEOUT) begin
            @(negedge sclk);
            waited++;
        end
        if (doneCount == startDone) begin
            reportTimeout("wr_done", waited);
            doReset();
            return;
        end
        bus.wr_grant = 1'b0;
        @(posedge sclk);
        #1;
    endtask

    // FIFO head / MIG ready model, updated just after each rising edge.
    initial begin
        bus.app_rdy       = 1'b0;
        bus.app_wdf_rdy   = 1'b0;
        bus.wfifo_rd_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        forever begin
            @(posedge sclk);
            #1;
            if (popFlag) begin
                if (fifoQ.size() > 0) void'(fifoQ.pop_front());
                popFlag = 1'b0;
            end
            bus.wfifo_rd_data = (fifoQ.size() > 0) ? fifoQ[0]
                              : {$urandom, $urandom, $urandom, $urandom};
            burstCyc = bus.wr_grant ? burstCyc + 1 : -1;
            case (mode)
                1: begin
                    bus.app_rdy     = !(burstCyc inside {[3:7]});
                    bus.app_wdf_rdy = !(burstCyc inside {[10:11]});
                end
                2: begin
                    bus.app_rdy     = (burstCyc >= 20);
                    bus.app_wdf_rdy = 1'b1;
                end
                3: begin
                    bus.app_rdy     = ($urandom_range(0, 9) < 7);
                    bus.app_wdf_rdy = ($urandom_range(0, 9) < 7);
                end
                4: begin
                    bus.app_rdy     = 1'b1;
                    bus.app_wdf_rdy = ($urandom_range(0, 9) < 3);
                end
                default: begin
                    bus.app_rdy     = 1'b1;
                    bus.app_wdf_rdy = 1'b1;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake seen mid-cycle.
    initial begin
        int   cyc = 0;
        int   enCount = 0;
        int   firstEnCyc = 0;
        bit   prevStall = 1'b0;
        bit   prevDone = 1'b0;
        logic [ADDR_W-1:0] prevAddr = '0;
        forever begin
            @(negedge sclk);
            cyc++;
            if (s_rst) begin
                enCount   = 0;
                prevStall = 1'b0;
                prevDone  = 1'b0;
                continue;
            end
            if (prevStall) begin
                checkOutput("app_en held in stall", 128'(bus.app_en), 128'(1));
                checkOutput("app_addr held in stall", 128'(bus.app_addr), 128'(prevAddr));
            end
            if (prevDone) begin
                checkOutput("wr_done one cycle", 128'(bus.wr_done), 128'(0));
                checkOutput("wr_req idle after done", 128'(bus.wr_req), 128'(0));
            end
            if (bus.app_en || bus.app_wdf_wren)
                checkOutput("wr_req low in burst", 128'(bus.wr_req), 128'(0));
            if (bus.app_en) begin
                if (enCount == 0) firstEnCyc = cyc;
                enCount++;
            end
            if (bus.app_en && bus.app_rdy) begin
                cmdAccInBurst++;
                if (expAddr.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL extra command: addr %0h, scoreboard empty", bus.app_addr);
                end else begin
                    checkOutput("app_addr", 128'(bus.app_addr), 128'(expAddr.pop_front()));
                    checkOutput("app_cmd", 128'(bus.app_cmd), 128'(0));
                end
            end
            if (bus.app_wdf_wren) begin
                checkOutput("wfifo_rd_en", 128'(bus.wfifo_rd_en), 128'(bus.app_wdf_rdy));
                checkOutput("app_wdf_end", 128'(bus.app_wdf_end), 128'(1));
            end
            if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
                popFlag = 1'b1;
                if (expData.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL extra data beat: %0h, scoreboard empty", bus.app_wdf_data);
                end else begin
                    checkOutput("app_wdf_data", bus.app_wdf_data, expData.pop_front());
                    checkOutput("app_wdf_mask", 128'(bus.app_wdf_mask), 128'(0));
                end
            end
            if (bus.wr_done) begin
                if (pendingDone == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected wr_done: got 1, expected 0");
                end else begin
                    checkOutput("commands left at done", 128'(expAddr.size()), 128'(0));
                    checkOutput("beats left at done", 128'(expData.size()), 128'(0));
                    if (mode == 0) begin
                        checkOutput("app_en cycles", 128'(enCount), 128'(BURST_LEN));
                        checkOutput("done latency", 128'(cyc - firstEnCyc), 128'(BURST_LEN));
                    end
                    pendingDone--;
                    doneCount++;
                end
                enCount = 0;
            end
            prevStall = bus.app_en && !bus.app_rdy;
            prevAddr  = bus.app_addr;
            prevDone  = bus.wr_done;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        s_rst                   = 1'b1;
        bus.init_calib_complete = 1'b0;
        bus.wr_trig             = 1'b0;
        bus.wr_grant            = 1'b0;
        repeat (3) @(posedge sclk);
        #2 checkReset("reset");
        @(posedge sclk);
        #1 s_rst = 1'b0;

        // wr_trig without calibration must not request the arbiter.
        mode = 0;
        loadBurst();
        bus.wr_trig = 1'b1;
        repeat (4) begin
            @(negedge sclk);
            checkOutput("wr_req without calib", 128'(bus.wr_req), 128'(0));
        end
        @(posedge sclk);
        #1 bus.init_calib_complete = 1'b1;
        @(negedge sclk);
        checkOutput("wr_req before calib sampled", 128'(bus.wr_req), 128'(0));
        @(negedge sclk);
        checkOutput("wr_req after calib", 128'(bus.wr_req), 128'(1));
        applyStimulus(0);

        // Stall patterns; these bursts walk the base through 128, 256 and wrap to 0.
        for (int m = 0; m < 3; m++) begin
            loadBurst();
            bus.wr_trig = 1'b1;
            applyStimulus(m);
        end
        for (int n = 0; n < 6; n++) begin
            loadBurst();
            bus.wr_trig = 1'b1;
            applyStimulus(($urandom_range(0, 1) == 0) ? 3 : 4);
        end

        // Reset after seven accepted commands abandons the burst.
        @(posedge sclk);
        #1;
        mode = 0;
        loadBurst();
        bus.wr_trig = 1'b1;
        waited = 0;
        while (!bus.wr_req && waited < TIMEOUT) begin
            @(negedge sclk);
            waited++;
        end
        if (!bus.wr_req) reportTimeout("wr_req before reset", waited);
        @(negedge sclk);
        cmdAccInBurst = 0;
        bus.wr_grant  = 1'b1;
        bus.wr_trig   = 1'b0;
        waited = 0;
        @(posedge sclk);
        while (cmdAccInBurst < 7 && waited < TIMEOUT) begin
            @(posedge sclk);
            waited++;
        end
        if (cmdAccInBurst < 7) reportTimeout("seven commands", waited);
        #1 s_rst = 1'b1;
        #2 checkReset("mid-burst reset");
        doReset();
        repeat (3) begin
            @(negedge sclk);
            checkOutput("quiet after reset", 128'(bus.wr_req), 128'(0));
        end

        @(posedge sclk);
        #1;
        loadBurst();
        bus.wr_trig = 1'b1;
        applyStimulus(0);
        loadBurst();
        bus.wr_trig = 1'b1;
        applyStimulus(3);

        repeat (5) @(posedge sclk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
